// File: rtl/register_file_pkg.sv
// Shared defaults for the register file: widths, register count and the
// index of the hard-wired zero register.
package register_file_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int ADDR_W_DEF   = 5;
   localparam int NUM_REGS_DEF = 32;
   localparam int ZERO_REG_IDX = 0;

endpackage : register_file_pkg

// File: rtl/register_file_read_port.sv
// One combinational read port: index mux, zero-register forcing and
// same-cycle write-through bypass, all suppressed while reset is asserted.
module register_file_read_port
   import register_file_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF
) (
   input  logic [DATA_W-1:0] regs [NUM_REGS],
   input  logic              reset,
   input  logic [ADDR_W-1:0] read_index,
   input  logic [ADDR_W-1:0] write_index,
   input  logic [DATA_W-1:0] write_data,
   input  logic              write_en,
   output logic [DATA_W-1:0] read_data
);

   // Priority: reset, then zero register, then bypass, then stored value.
   always_comb begin
      read_data = '0;
      if (!reset) begin
         read_data = '0;
      end else if (read_index == ADDR_W'(ZERO_REG_IDX)) begin
         read_data = '0;
      end else if (write_en && (write_index == read_index)) begin
         read_data = write_data;
      end else begin
         read_data = regs[read_index];
      end
   end

endmodule : register_file_read_port

// File: rtl/register_file.sv
// Two-read, one-write register file with a hard-wired zero register and
// write-through bypass; storage clears on a synchronous active-low reset.
module register_file
   import register_file_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] ReadRegister1,
   input  logic [ADDR_W-1:0] ReadRegister2,
   input  logic [ADDR_W-1:0] WriteRegister,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              RegWrite,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2
);

   logic [DATA_W-1:0] regs_r [NUM_REGS];
   logic              write_en_s;

   assign write_en_s = RegWrite && (WriteRegister != ADDR_W'(ZERO_REG_IDX));

   // Storage update: reset clears everything and wins over a coincident write.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= '0;
         end
      end else if (write_en_s) begin
         regs_r[WriteRegister] <= WriteData;
      end
   end

   register_file_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_read_port1 (
      .regs        (regs_r),
      .reset       (reset),
      .read_index  (ReadRegister1),
      .write_index (WriteRegister),
      .write_data  (WriteData),
      .write_en    (RegWrite),
      .read_data   (ReadData1)
   );

   register_file_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_read_port2 (
      .regs        (regs_r),
      .reset       (reset),
      .read_index  (ReadRegister2),
      .write_index (WriteRegister),
      .write_data  (WriteData),
      .write_en    (RegWrite),
      .read_data   (ReadData2)
   );

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed literal scenarios plus
// randomized traffic compared every cycle against an array-based model.
module tb_register_file;

   logic        clk;
   logic        reset;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [4:0]  WriteRegister;
   logic [31:0] WriteData;
   logic        RegWrite;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;

   int errors = 0;
   int checks = 0;

   logic [31:0] model [32];
   logic        model_ok = 1'b0;

   register_file dut (
      .clk           (clk),
      .reset         (reset),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .RegWrite      (RegWrite),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // What a read port must show right now, from the architectural rules.
   function automatic logic [31:0] expect_read(input logic [4:0] idx);
      if (reset !== 1'b1)                       return 32'h0;
      if (idx == 5'd0)                          return 32'h0;
      if (RegWrite && (WriteRegister == idx))   return WriteData;
      return model[idx];
   endfunction

   // Architectural state: cleared on reset edges, one write per edge otherwise.
   always @(posedge clk) begin
      if (reset === 1'b0) begin
         for (int i = 0; i < 32; i++) model[i] <= 32'h0;
         model_ok <= 1'b1;
      end else if (RegWrite && (WriteRegister != 5'd0)) begin
         model[WriteRegister] <= WriteData;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (model_ok) begin
         check("model_rd1", ReadData1, expect_read(ReadRegister1));
         check("model_rd2", ReadData2, expect_read(ReadRegister2));
      end
   end

   task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
      WriteRegister = addr;
      WriteData     = data;
      RegWrite      = 1'b1;
      @(posedge clk);
      #1;
      RegWrite      = 1'b0;
   endtask

   initial begin
      reset         = 1'b0;
      RegWrite      = 1'b0;
      WriteRegister = 5'd0;
      WriteData     = 32'h0;
      ReadRegister1 = 5'd0;
      ReadRegister2 = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // Reset and read-all
      for (int i = 0; i < 32; i++) begin
         ReadRegister1 = 5'(i);
         ReadRegister2 = 5'(31 - i);
         #1;
         check("reset_rd1", ReadData1, 32'h0000_0000);
         check("reset_rd2", ReadData2, 32'h0000_0000);
      end
      @(posedge clk);
      #1;

      // Write then read
      do_write(5'd5, 32'h1234_5678);
      do_write(5'd31, 32'hDEAD_BEEF);
      ReadRegister1 = 5'd5;
      ReadRegister2 = 5'd31;
      #1;
      check("wr_r5", ReadData1, 32'h1234_5678);
      check("wr_r31", ReadData2, 32'hDEAD_BEEF);
      ReadRegister1 = 5'd6;
      #1;
      check("wr_r6", ReadData1, 32'h0000_0000);

      // Register zero
      RegWrite      = 1'b1;
      WriteRegister = 5'd0;
      WriteData     = 32'hFFFF_FFFF;
      ReadRegister1 = 5'd0;
      ReadRegister2 = 5'd0;
      #1;
      check("r0_pre_rd1", ReadData1, 32'h0);
      check("r0_pre_rd2", ReadData2, 32'h0);
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
      #1;
      check("r0_post_rd1", ReadData1, 32'h0);
      check("r0_post_rd2", ReadData2, 32'h0);

      // Bypass
      do_write(5'd7, 32'h1111_1111);
      RegWrite      = 1'b1;
      WriteRegister = 5'd7;
      WriteData     = 32'h2222_2222;
      ReadRegister1 = 5'd7;
      ReadRegister2 = 5'd7;
      #1;
      check("bypass_rd1", ReadData1, 32'h2222_2222);
      check("bypass_rd2", ReadData2, 32'h2222_2222);
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
      #1;
      check("bypass_after", ReadData1, 32'h2222_2222);

      // Enable low
      RegWrite      = 1'b0;
      WriteRegister = 5'd3;
      WriteData     = 32'hAAAA_5555;
      @(posedge clk);
      #1;
      ReadRegister1 = 5'd3;
      #1;
      check("en_low_r3", ReadData1, 32'h0);

      // Reset mid-operation, with a coincident write that must be lost
      do_write(5'd9, 32'hCAFE_F00D);
      ReadRegister1 = 5'd9;
      #1;
      check("r9_set", ReadData1, 32'hCAFE_F00D);
      reset         = 1'b0;
      RegWrite      = 1'b1;
      WriteRegister = 5'd9;
      WriteData     = 32'h0000_0001;
      ReadRegister2 = 5'd9;
      #1;
      check("in_reset_rd1", ReadData1, 32'h0);
      check("in_reset_rd2", ReadData2, 32'h0);
      @(posedge clk);
      #1;
      reset    = 1'b1;
      RegWrite = 1'b0;
      for (int i = 0; i < 32; i++) begin
         ReadRegister1 = 5'(i);
         ReadRegister2 = 5'(31 - i);
         #1;
         check("midrst_rd1", ReadData1, 32'h0);
         check("midrst_rd2", ReadData2, 32'h0);
      end
      @(posedge clk);
      #1;

      // Randomized traffic, checked by the per-cycle compare process
      for (int n = 0; n < 3000; n++) begin
         reset         = ($urandom_range(99) < 3) ? 1'b0 : 1'b1;
         RegWrite      = 1'($urandom_range(1));
         WriteRegister = 5'($urandom_range(31));
         WriteData     = $urandom;
         ReadRegister1 = ($urandom_range(3) == 0) ? WriteRegister : 5'($urandom_range(31));
         ReadRegister2 = ($urandom_range(3) == 0) ? ReadRegister1 : 5'($urandom_range(31));
         @(posedge clk);
         #1;
      end

      reset    = 1'b1;
      RegWrite = 1'b0;
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_register_file
